// File: rtl/seq_counter_pkg.sv
// Shared types and constants for the sequence counter controller:
// FSM states, run-mode encodings, size defaults and the power-on table contents.
package seq_counter_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_STEP    = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Entries beyond RST_LEN come up as zero.
  localparam int unsigned RST_LEN = 5;
  localparam logic [RST_LEN-1:0][7:0] RST_TABLE = {8'd6, 8'd4, 8'd2, 8'd1, 8'd0};

  function automatic logic [7:0] rst_entry(input int unsigned idx);
    logic [7:0] val;
    val = 8'd0;
    for (int unsigned k = 0; k < RST_LEN; k++) begin
      if (k == idx) begin
        val = RST_TABLE[k];
      end else begin
        val = val;
      end
    end
    return val;
  endfunction

endpackage

// File: rtl/seq_counter_ctrl_if.sv
// Configuration, control and output handshake bundle of the sequence counter.
// The master side drives configuration/control; the slave side is the controller.
interface seq_counter_ctrl_if
  import seq_counter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [LW-1:0]    cfg_len;
  logic [1:0]       mode;
  logic             start;
  logic             stop;
  logic             step;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] counter;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_len, mode, start, stop, step, out_ready,
    input  out_valid, counter, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_len, mode, start, stop, step, out_ready,
    output out_valid, counter, busy, done, cfg_err
  );

endinterface

// File: rtl/seq_counter_ctrl_table.sv
// Sequence table: DEPTH entries of WIDTH bits, synchronous write, asynchronous read,
// reloaded from the package constant on reset.
module seq_table
  import seq_counter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next table contents: at most one entry replaced per cycle.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Table storage with synchronous reload of the power-on contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(rst_entry(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/seq_counter_ctrl.sv
// Sequence counter controller: steps through a programmable table of values in
// free-run, one-shot or single-step mode behind a valid/ready output handshake.
module seq_counter_ctrl
  import seq_counter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               reset,
  seq_counter_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] index_q, index_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic             start_ok;
  logic             last;
  logic             handshake;
  logic             tbl_we;
  logic [WIDTH-1:0] tbl_rdata;

  seq_table #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (index_q),
    .rdata (tbl_rdata)
  );

  // Next-state, index and output decode for the controller.
  always_comb begin
    start_ok  = (bus.cfg_len != {LW{1'b0}}) && (bus.cfg_len <= DEPTH_L) &&
                (bus.mode != MODE_RSVD);
    last      = ({1'b0, index_q} == (len_q - LW'(1)));
    handshake = out_valid_q && bus.out_ready;
    tbl_we    = bus.cfg_we && (state_q == ST_IDLE);

    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    index_d = index_q;

    // Stop outranks handshake, step and start in every non-idle state.
    if ((state_q != ST_IDLE) && bus.stop) begin
      state_d = ST_IDLE;
      index_d = {AW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && start_ok) begin
            state_d = ST_RUN;
            mode_d  = mode_e'(bus.mode);
            len_d   = bus.cfg_len;
            index_d = {AW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (handshake && last) begin
            case (mode_q)
              MODE_FREE: begin
                index_d = {AW{1'b0}};
              end
              MODE_ONESHOT: begin
                state_d = ST_DONE;
              end
              MODE_STEP: begin
                index_d = {AW{1'b0}};
                state_d = ST_STEP_WAIT;
              end
              default: begin
                index_d = {AW{1'b0}};
                state_d = ST_IDLE;
              end
            endcase
          end else if (handshake) begin
            index_d = index_q + AW'(1);
            if (mode_q == MODE_STEP) begin
              state_d = ST_STEP_WAIT;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STEP_WAIT: begin
          if (bus.step) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STEP_WAIT;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          index_d = {AW{1'b0}};
        end
        default: begin
          state_d = ST_IDLE;
          index_d = {AW{1'b0}};
        end
      endcase
    end

    cfg_err_d   = ((state_q == ST_IDLE) && bus.start && !start_ok) ||
                  (bus.cfg_we && (state_q != ST_IDLE));
    out_valid_d = (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_FREE;
      len_q       <= {LW{1'b0}};
      index_q     <= {AW{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      index_q     <= index_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.counter   = tbl_rdata;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule
